// File: rtl/uart_axi_lite.sv
// UART with an AXI4-Lite register interface: 16-deep TX and RX byte FIFOs,
// 8N1 framing, a sticky overrun and frame-error status, and FIFO flush control.
module uart_axi_lite #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [3:0]  axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic        rxd,
  output logic        txd
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_PER_BIT / 2 - 1);

  localparam logic [1:0] REG_RX   = 2'd0;
  localparam logic [1:0] REG_TX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Protection, strobes, upper data bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{axi_arprot, axi_awprot, axi_wstrb, axi_wdata[31:8],
                           axi_araddr[1:0], axi_awaddr[1:0]};

  tx_state_t        tx_state;
  logic [BW-1:0]    tx_baud;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  rx_state_t        rx_state;
  logic [BW-1:0]    rx_baud;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_s1;
  logic             rx_s2;

  logic [7:0]       tx_mem [16];
  logic [3:0]       tx_wr;
  logic [3:0]       tx_rd;
  logic [4:0]       tx_count;
  logic [7:0]       rx_mem [16];
  logic [3:0]       rx_wr;
  logic [3:0]       rx_rd;
  logic [4:0]       rx_count;

  logic             overrun;
  logic             frame_err;
  logic             rd_stat;

  logic [1:0]       rd_sel;
  logic [1:0]       wr_sel;
  logic             ar_hs;
  logic             aw_hs;
  logic             tx_full;
  logic             tx_empty;
  logic             rx_full;
  logic             rx_empty;
  logic             tx_pop;
  logic             tx_push;
  logic             tx_clear;
  logic             rx_pop;
  logic             rx_push;
  logic             rx_clear;
  logic             rx_frame_done;
  logic             overrun_set;
  logic             frame_set;
  logic             stat_clear;
  logic [31:0]      stat_word;

  // Ready is granted combinationally so one transfer completes every two cycles; held low in reset.
  assign axi_arready = axi_arvalid && !axi_rvalid && !rst;
  assign axi_awready = axi_awvalid && axi_wvalid && !axi_bvalid && !rst;
  assign axi_wready  = axi_awready;
  assign axi_rresp   = 2'b00;
  assign axi_bresp   = 2'b00;

  assign rd_sel = axi_araddr[3:2];
  assign wr_sel = axi_awaddr[3:2];
  assign ar_hs  = axi_arvalid && axi_arready;
  assign aw_hs  = axi_awready;

  assign tx_full  = tx_count[4];
  assign tx_empty = (tx_count == 5'd0);
  assign rx_full  = rx_count[4];
  assign rx_empty = (rx_count == 5'd0);

  assign tx_pop   = (tx_state == TX_IDLE) && !tx_empty;
  assign tx_push  = aw_hs && (wr_sel == REG_TX) && (!tx_full || tx_pop);
  assign tx_clear = aw_hs && (wr_sel == REG_CTRL) && axi_wdata[0];

  assign rx_frame_done = (rx_state == RX_STOP) && (rx_baud == BAUD_LAST);
  assign rx_pop        = ar_hs && (rd_sel == REG_RX) && !rx_empty;
  assign rx_push       = rx_frame_done && rx_s2 && (!rx_full || rx_pop);
  assign rx_clear      = aw_hs && (wr_sel == REG_CTRL) && axi_wdata[1];
  assign overrun_set   = rx_frame_done && rx_s2 && rx_full && !rx_pop;
  assign frame_set     = rx_frame_done && !rx_s2;
  assign stat_clear    = axi_rvalid && axi_rready && rd_stat;

  assign stat_word = {25'd0, frame_err, overrun, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};

  // TX FIFO storage; entries need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= axi_wdata[7:0];
  end

  // TX FIFO pointers and count; a flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr    <= 4'd0;
      tx_rd    <= 4'd0;
      tx_count <= 5'd0;
    end else if (tx_clear) begin
      tx_wr    <= 4'd0;
      tx_rd    <= 4'd0;
      tx_count <= 5'd0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 4'd1;
      if (tx_pop)  tx_rd <= tx_rd + 4'd1;
      tx_count <= tx_count + 5'(tx_push) - 5'(tx_pop);
    end
  end

  // RX FIFO storage, written with the assembled byte at the end of a good frame.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  // RX FIFO pointers and count; a flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr    <= 4'd0;
      rx_rd    <= 4'd0;
      rx_count <= 5'd0;
    end else if (rx_clear) begin
      rx_wr    <= 4'd0;
      rx_rd    <= 4'd0;
      rx_count <= 5'd0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 4'd1;
      if (rx_pop)  rx_rd <= rx_rd + 4'd1;
      rx_count <= rx_count + 5'(rx_push) - 5'(rx_pop);
    end
  end

  // Sticky error flags: a new event outranks a STAT-read clear landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)     overrun <= 1'b1;
      else if (stat_clear) overrun <= 1'b0;
      if (frame_set)       frame_err <= 1'b1;
      else if (stat_clear) frame_err <= 1'b0;
    end
  end

  // Read channel: capture the addressed register at address acceptance and hold it until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= 32'd0;
      rd_stat    <= 1'b0;
    end else if (ar_hs) begin
      axi_rvalid <= 1'b1;
      rd_stat    <= (rd_sel == REG_STAT);
      case (rd_sel)
        REG_RX:   axi_rdata <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd]};
        REG_STAT: axi_rdata <= stat_word;
        default:  axi_rdata <= 32'd0;
      endcase
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid <= 1'b0;
      rd_stat    <= 1'b0;
    end
  end

  // Write response: raised the cycle after the write is accepted, held until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          axi_bvalid <= 1'b0;
    else if (aw_hs)                   axi_bvalid <= 1'b1;
    else if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
  end

  // Transmitter: pops a byte when idle and shifts it out 8N1, LSB first, with txd registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          txd     <= 1'b1;
          tx_baud <= '0;
          tx_bit  <= 3'd0;
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd];
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud  <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_baud <= tx_baud + BW'(1);
          end
        end
        TX_DATA: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end else begin
            tx_baud <= tx_baud + BW'(1);
          end
        end
        TX_STOP: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud  <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_baud <= tx_baud + BW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  // Receiver: confirms the start bit at mid-bit, then samples data and stop one bit apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_baud <= '0;
          rx_bit  <= 3'd0;
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_baud == BAUD_HALF) begin
            rx_baud  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + BW'(1);
          end
        end
        RX_DATA: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_baud <= rx_baud + BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_baud <= rx_baud + BW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axi_lite.sv
// Self-checking bench for uart_axi_lite: directed scenarios plus a randomized
// phase, all compared against a queue-based model of the UART's behaviour.
module tb_uart_axi_lite;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  axi_araddr = 4'd0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [2:0]  axi_arprot = 3'd0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b1;
  logic [3:0]  axi_awaddr = 4'd0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [2:0]  axi_awprot = 3'd0;
  logic [31:0] axi_wdata = 32'd0;
  logic [3:0]  axi_wstrb = 4'hF;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_model [$];
  logic [7:0] tx_exp [$];
  logic       m_ovr = 1'b0;
  logic       m_frame = 1'b0;
  logic       mon_en = 1'b1;
  logic       tog_en = 1'b0;
  int         toggles = 0;

  uart_axi_lite #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  // Single point of comparison: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Expected RX read: head of the model FIFO, or 0 when empty.
  function automatic logic [31:0] modelReadRx();
    if (rx_model.size() == 0) return 32'd0;
    return {24'd0, rx_model.pop_front()};
  endfunction

  // Expected STAT read with the TX side drained; reading clears the sticky flags.
  function automatic logic [31:0] modelReadStat();
    logic [31:0] s;
    s = {25'd0, m_frame, m_ovr, 3'b001, rx_model.size() == 16, rx_model.size() != 0};
    m_ovr = 1'b0;
    m_frame = 1'b0;
    return s;
  endfunction

  // Model of one received frame: good frames are kept if there is room, else overrun.
  function automatic void modelRxFrame(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) m_frame = 1'b1;
    else if (rx_model.size() < 16) rx_model.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  // Serial decoder on txd: checks framing and compares each byte to the expected stream.
  always begin : tx_monitor
    logic [7:0] got;
    logic en, start_ok, stop_ok;
    @(negedge txd);
    en = mon_en;
    repeat (2) @(posedge clk);
    #1 start_ok = (txd == 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 got[i] = txd;
    end
    repeat (CPB) @(posedge clk);
    #1 stop_ok = txd;
    if (en) begin
      checkOutput("tx_start_bit", {31'd0, start_ok}, 32'd1);
      checkOutput("tx_stop_bit", {31'd0, stop_ok}, 32'd1);
      checkOutput("tx_byte_expected", {31'd0, tx_exp.size() != 0}, 32'd1);
      if (tx_exp.size() != 0) checkOutput("tx_byte", {24'd0, got}, {24'd0, tx_exp.pop_front()});
    end
  end

  // Counts txd edges while enabled, to show the line stays quiet.
  always @(txd) begin
    if (tog_en) toggles++;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time %0t reached limit 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, output int lat);
    int n;
    axi_awaddr = addr;
    axi_wdata = data;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 20) begin n++; @(negedge clk); end
    if (!axi_awready) checkOutput("awready_timeout", {31'd0, axi_awready}, 32'd1);
    @(posedge clk);
    #1;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    n++;
    @(negedge clk);
    while (!axi_bvalid && n < 40) begin n++; @(negedge clk); end
    if (!axi_bvalid) checkOutput("bvalid_timeout", {31'd0, axi_bvalid}, 32'd1);
    checkOutput("bresp", {30'd0, axi_bresp}, 32'd0);
    lat = n;
    @(posedge clk);
    #1;
  endtask

  task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
    int n;
    axi_araddr = addr;
    axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_arready && n < 20) begin n++; @(negedge clk); end
    if (!axi_arready) checkOutput("arready_timeout", {31'd0, axi_arready}, 32'd1);
    @(posedge clk);
    #1;
    axi_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!axi_rvalid && n < 20) begin n++; @(negedge clk); end
    if (!axi_rvalid) checkOutput("rvalid_timeout", {31'd0, axi_rvalid}, 32'd1);
    checkOutput("rresp", {30'd0, axi_rresp}, 32'd0);
    data = axi_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axiRead(addr, d);
    checkOutput(tag, d, exp);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    modelRxFrame(b, stop_bit);
  endtask

  task automatic waitTxDrain(input int limit);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < limit) begin n++; @(posedge clk); end
    #1;
    checkOutput("tx_drained", tx_exp.size(), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Randomized mix of serial frames, register reads/writes and flushes.
  task automatic applyStimulus(input int iterations);
    int lat;
    logic [31:0] d;
    logic [7:0] b;
    for (int it = 0; it < iterations; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin
          b = 8'($urandom);
          sendFrame(b, $urandom_range(0, 7) != 0);
        end
        2, 3: readCheck("rand_rx", 4'h0 | 4'($urandom_range(0, 3)), modelReadRx());
        4: readCheck("rand_stat", 4'h8, modelReadStat());
        5: begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            b = 8'($urandom);
            tx_exp.push_back(b);
            axiWrite(4'h4, {24'($urandom), b}, lat);
          end
          waitTxDrain(600);
        end
        6: begin
          readCheck("rand_wo_read", ($urandom_range(0, 1) != 0) ? 4'h4 : 4'hC, 32'd0);
          axiWrite(($urandom_range(0, 1) != 0) ? 4'h0 : 4'h8, $urandom, lat);
        end
        default: begin
          d = $urandom;
          axiWrite(4'hC, d, lat);
          if (d[1]) rx_model.delete();
        end
      endcase
    end
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    logic [7:0] b;
    logic [9:0] pat;
    int n;

    #1 rst = 1'b1;
    axi_arvalid = 1'b1;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_txd", {31'd0, txd}, 32'd1);
    checkOutput("rst_arready", {31'd0, axi_arready}, 32'd0);
    checkOutput("rst_awready", {31'd0, axi_awready}, 32'd0);
    checkOutput("rst_wready", {31'd0, axi_wready}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    checkOutput("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    checkOutput("rst_rdata", axi_rdata, 32'd0);
    checkOutput("rst_rresp", {30'd0, axi_rresp}, 32'd0);
    checkOutput("rst_bresp", {30'd0, axi_bresp}, 32'd0);
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    readCheck("post_rst_stat", 4'h8, modelReadStat());
    readCheck("post_rst_rx", 4'h0, modelReadRx());

    // 0xA5 goes out bit by bit, each bit held CPB cycles.
    tx_exp.push_back(8'hA5);
    axiWrite(4'h4, 32'h000000A5, lat);
    checkOutput("bvalid_within_2", {31'd0, lat <= 2}, 32'd1);
    pat = {1'b1, 8'hA5, 1'b0};
    n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 20) begin n++; @(negedge clk); end
    for (int i = 0; i < 10 * CPB; i++) begin
      checkOutput("a5_txd_bit", {31'd0, txd}, {31'd0, pat[i / CPB]});
      @(negedge clk);
    end
    waitTxDrain(200);

    // Single received byte.
    sendFrame(8'h3C, 1'b1);
    readCheck("rx1_stat", 4'h8, modelReadStat());
    readCheck("rx1_data", 4'h0, modelReadRx());
    readCheck("rx1_empty_read", 4'h0, modelReadRx());
    readCheck("rx1_stat_after", 4'h8, modelReadStat());

    // Seventeen frames overflow the RX FIFO by one.
    for (int i = 0; i <= 16; i++) sendFrame(8'(i), 1'b1);
    readCheck("ovr_stat", 4'h8, modelReadStat());
    for (int i = 0; i < 16; i++) readCheck("ovr_rx_data", 4'h0, modelReadRx());
    readCheck("ovr_stat_cleared", 4'h8, modelReadStat());

    // Bad stop bit raises frame error, cleared by the next STAT read.
    sendFrame(8'($urandom), 1'b0);
    readCheck("frame_err_stat", 4'h8, modelReadStat());
    readCheck("frame_err_cleared", 4'h8, modelReadStat());
    readCheck("frame_err_no_push", 4'h0, modelReadRx());

    // Seventeen back-to-back TX writes fill the FIFO behind the byte being sent.
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      axiWrite(4'h4, {24'd0, b}, lat);
    end
    axiRead(4'h8, d);
    checkOutput("tx_full_stat", d & 32'h0000000C, 32'h00000008);

    // Response held while bready is low, and no new write accepted meanwhile.
    axi_bready = 1'b0;
    axi_awaddr = 4'h8;
    axi_wdata = $urandom;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 20) begin n++; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_bvalid", {31'd0, axi_bvalid}, 32'd1);
      checkOutput("hold_awready", {31'd0, axi_awready}, 32'd0);
    end
    @(posedge clk);
    #1 axi_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 20) begin n++; @(negedge clk); end
    @(posedge clk);
    #1;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (axi_bvalid && n < 20) begin n++; @(negedge clk); end
    checkOutput("hold_bvalid_released", {31'd0, axi_bvalid}, 32'd0);
    waitTxDrain(1000);

    applyStimulus(40);
    readCheck("rand_final_stat", 4'h8, modelReadStat());

    // Reset in the middle of a character forces the line idle and discards everything.
    mon_en = 1'b0;
    axiWrite(4'h4, 32'h0000005A, lat);
    axiWrite(4'h4, 32'h000000C3, lat);
    n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 20) begin n++; @(negedge clk); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("mid_rst_txd", {31'd0, txd}, 32'd1);
    rx_model.delete();
    m_ovr = 1'b0;
    m_frame = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    toggles = 0;
    tog_en = 1'b1;
    repeat (60) @(posedge clk);
    #1 tog_en = 1'b0;
    checkOutput("post_rst_toggles", toggles, 32'd0);
    readCheck("post_mid_rst_stat", 4'h8, modelReadStat());
    mon_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
